// File: rtl/sdrc_host_pack_if.sv
// Host and application bus bundle for the host width adapter.
// The slave modport is the adapter's view; the master modport is the host/controller side.
interface sdrc_host_pack_if;
    logic [31:0] h_wr_data;
    logic [3:0]  h_wr_be;
    logic        h_wr_valid;
    logic        h_wr_last;
    logic        h_wr_ready;

    logic [31:0] app_wr_data;
    logic [3:0]  app_wr_en_n;
    logic        app_wr_valid;
    logic        app_wr_next;

    logic [31:0] app_rd_data;
    logic        app_rd_valid;
    logic        app_last_rd;

    logic [31:0] h_rd_data;
    logic        h_rd_valid;
    logic        h_rd_last;
    logic        h_rd_ready;

    modport slave (
        input  h_wr_data, h_wr_be, h_wr_valid, h_wr_last,
        output h_wr_ready,
        output app_wr_data, app_wr_en_n, app_wr_valid,
        input  app_wr_next,
        input  app_rd_data, app_rd_valid, app_last_rd,
        output h_rd_data, h_rd_valid, h_rd_last,
        input  h_rd_ready
    );

    modport master (
        output h_wr_data, h_wr_be, h_wr_valid, h_wr_last,
        input  h_wr_ready,
        input  app_wr_data, app_wr_en_n, app_wr_valid,
        output app_wr_next,
        output app_rd_data, app_rd_valid, app_last_rd,
        input  h_rd_data, h_rd_valid, h_rd_last,
        output h_rd_ready
    );
endinterface

// File: rtl/sdrc_host_pack.sv
// Width adapter between an 8/16/32-bit host and a 32-bit application data port.
// Writes are packed into byte-enabled words; reads are buffered and unpacked into host beats.
module sdrc_host_pack #(
    parameter int APP_DW   = 32,
    parameter int RD_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             host_width,
    sdrc_host_pack_if.slave        bus,
    output logic                   wr_underrun,
    output logic                   rd_overflow
);
    localparam int AW = $clog2(RD_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(RD_DEPTH);

    logic [1:0]        maxl;
    logic [APP_DW-1:0] asm_data_q, asm_data_d, merge_data;
    logic [3:0]        asm_en_n_q, asm_en_n_d, merge_en_n;
    logic [1:0]        wr_lane_q, wr_lane_d;
    logic [APP_DW-1:0] app_data_q, app_data_d;
    logic [3:0]        app_en_n_q, app_en_n_d;
    logic              app_valid_q, app_valid_d;
    logic              underrun_q, underrun_d;
    logic              wr_fire;

    logic [APP_DW:0]   fifo_q [RD_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [1:0]        rd_lane_q, rd_lane_d;
    logic              overflow_q, overflow_d;
    logic              rd_valid, rd_end, push, pop, full;
    logic [APP_DW-1:0] head_data, rd_beat;
    logic              head_last;

    assign maxl = host_width[1] ? 2'd3 : (host_width[0] ? 2'd1 : 2'd0);

    // ---------------- write path ----------------
    assign wr_fire = bus.h_wr_valid & ~app_valid_q;

    always_comb begin
        merge_data = asm_data_q;
        merge_en_n = asm_en_n_q;
        if (host_width[1]) begin
            merge_data[{wr_lane_q, 3'b000} +: 8] = bus.h_wr_data[7:0];
            merge_en_n[wr_lane_q]                = ~bus.h_wr_be[0];
        end else if (host_width[0]) begin
            merge_data[{wr_lane_q[0], 4'b0000} +: 16] = bus.h_wr_data[15:0];
            merge_en_n[{wr_lane_q[0], 1'b0} +: 2]     = ~bus.h_wr_be[1:0];
        end else begin
            merge_data = bus.h_wr_data;
            merge_en_n = ~bus.h_wr_be;
        end
    end

    always_comb begin
        asm_data_d  = asm_data_q;
        asm_en_n_d  = asm_en_n_q;
        wr_lane_d   = wr_lane_q;
        app_data_d  = app_data_q;
        app_en_n_d  = app_en_n_q;
        app_valid_d = app_valid_q;
        underrun_d  = underrun_q;
        // wr_fire needs app_valid_q low, so the two branches never fight over app_valid_d
        if (bus.app_wr_next) begin
            if (app_valid_q) app_valid_d = 1'b0;
            else             underrun_d  = 1'b1;
        end
        if (wr_fire) begin
            if (wr_lane_q == maxl || bus.h_wr_last) begin
                app_data_d  = merge_data;
                app_en_n_d  = merge_en_n;
                app_valid_d = 1'b1;
                asm_data_d  = '0;
                asm_en_n_d  = 4'hF;
                wr_lane_d   = 2'd0;
            end else begin
                asm_data_d = merge_data;
                asm_en_n_d = merge_en_n;
                wr_lane_d  = wr_lane_q + 2'd1;
            end
        end
    end

    // ---------------- read path ----------------
    assign rd_valid  = (count_q != '0);
    assign rd_end    = (rd_lane_q == maxl);
    assign pop       = rd_valid & bus.h_rd_ready & rd_end;
    assign full      = (count_q == FULL_CNT);
    assign push      = bus.app_rd_valid & (~full | pop);
    assign head_data = fifo_q[rd_ptr_q][APP_DW-1:0];
    assign head_last = fifo_q[rd_ptr_q][APP_DW];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_lane_d  = rd_lane_q;
        overflow_d = overflow_q | (bus.app_rd_valid & full & ~pop);
        count_d    = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (rd_valid && bus.h_rd_ready) rd_lane_d = rd_end ? 2'd0 : rd_lane_q + 2'd1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rd_beat = '0;
        if (host_width[1])      rd_beat = {24'b0, head_data[{rd_lane_q, 3'b000} +: 8]};
        else if (host_width[0]) rd_beat = {16'b0, head_data[{rd_lane_q[0], 4'b0000} +: 16]};
        else                    rd_beat = head_data;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_data_q  <= '0;
            asm_en_n_q  <= 4'hF;
            wr_lane_q   <= 2'd0;
            app_data_q  <= '0;
            app_en_n_q  <= 4'hF;
            app_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_lane_q   <= 2'd0;
            overflow_q  <= 1'b0;
        end else begin
            asm_data_q  <= asm_data_d;
            asm_en_n_q  <= asm_en_n_d;
            wr_lane_q   <= wr_lane_d;
            app_data_q  <= app_data_d;
            app_en_n_q  <= app_en_n_d;
            app_valid_q <= app_valid_d;
            underrun_q  <= underrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_lane_q   <= rd_lane_d;
            overflow_q  <= overflow_d;
        end
    end

    // storage needs no reset; count gates everything read from it
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {bus.app_last_rd, bus.app_rd_data};
    end

    assign bus.h_wr_ready   = ~app_valid_q;
    assign bus.app_wr_data  = app_data_q;
    assign bus.app_wr_en_n  = app_en_n_q;
    assign bus.app_wr_valid = app_valid_q;
    assign bus.h_rd_valid   = rd_valid;
    assign bus.h_rd_data    = rd_valid ? rd_beat : '0;
    assign bus.h_rd_last    = rd_valid & head_last & rd_end;
    assign wr_underrun      = underrun_q;
    assign rd_overflow      = overflow_q;
endmodule

// File: tb/tb_sdrc_host_pack.sv
// Directed bench for sdrc_host_pack: stimulus queues expected words/beats,
// independent monitors compare them as the DUT presents write words and read beats.
module tb_sdrc_host_pack;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] host_width;
    logic       wr_underrun, rd_overflow;

    sdrc_host_pack_if bus();

    sdrc_host_pack #(.APP_DW(32), .RD_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .host_width  (host_width),
        .bus         (bus),
        .wr_underrun (wr_underrun),
        .rd_overflow (rd_overflow)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct { logic [31:0] d; logic [3:0] en_n; } wexp_t;
    typedef struct { logic [31:0] d; logic last; } rexp_t;
    wexp_t wq[$];
    rexp_t rq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_w(input logic [31:0] d, input logic [3:0] en_n);
        wexp_t e;
        e.d = d; e.en_n = en_n;
        wq.push_back(e);
    endtask

    task automatic push_r(input logic [31:0] d, input logic last);
        rexp_t e;
        e.d = d; e.last = last;
        rq.push_back(e);
    endtask

    task automatic wr_beat(input logic [31:0] d, input logic [3:0] be, input logic last);
        int n;
        bus.h_wr_data  = d;
        bus.h_wr_be    = be;
        bus.h_wr_last  = last;
        bus.h_wr_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.h_wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("wr_beat_timeout", 32'(bus.h_wr_ready), 32'd1);
        @(posedge clk); #1;
        bus.h_wr_valid = 1'b0;
        bus.h_wr_last  = 1'b0;
    endtask

    task automatic consume_word();
        int n;
        n = 0;
        while (!bus.app_wr_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("consume_timeout", 32'(bus.app_wr_valid), 32'd1);
        bus.app_wr_next = 1'b1;
        @(posedge clk); #1;
        bus.app_wr_next = 1'b0;
    endtask

    task automatic rd_push(input logic [31:0] d, input logic last);
        bus.app_rd_data  = d;
        bus.app_last_rd  = last;
        bus.app_rd_valid = 1'b1;
        @(posedge clk); #1;
        bus.app_rd_valid = 1'b0;
        bus.app_last_rd  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_app_wr_valid"}, 32'(bus.app_wr_valid), 32'd0);
        chk({tag, "_app_wr_data"},  bus.app_wr_data,       32'd0);
        chk({tag, "_app_wr_en_n"},  32'(bus.app_wr_en_n),  32'hF);
        chk({tag, "_h_wr_ready"},   32'(bus.h_wr_ready),   32'd1);
        chk({tag, "_h_rd_valid"},   32'(bus.h_rd_valid),   32'd0);
        chk({tag, "_h_rd_last"},    32'(bus.h_rd_last),    32'd0);
        chk({tag, "_h_rd_data"},    bus.h_rd_data,         32'd0);
        chk({tag, "_wr_underrun"},  32'(wr_underrun),      32'd0);
        chk({tag, "_rd_overflow"},  32'(rd_overflow),      32'd0);
    endtask

    // write monitor: compares each newly presented word
    logic prev_wv = 1'b0;
    initial forever begin
        @(negedge clk);
        if (bus.app_wr_valid === 1'b1 && prev_wv !== 1'b1) begin
            if (wq.size() == 0) begin
                chk("wr_unexpected_word", bus.app_wr_data, 32'hxxxx_xxxx);
            end else begin
                wexp_t e;
                e = wq.pop_front();
                chk("wr_data", bus.app_wr_data, e.d);
                chk("wr_en_n", 32'(bus.app_wr_en_n), 32'(e.en_n));
            end
        end
        prev_wv = bus.app_wr_valid;
    end

    // read monitor: compares every accepted host beat
    initial forever begin
        @(negedge clk);
        if (bus.h_rd_valid === 1'b1 && bus.h_rd_ready === 1'b1) begin
            if (rq.size() == 0) begin
                chk("rd_unexpected_beat", bus.h_rd_data, 32'hxxxx_xxxx);
            end else begin
                rexp_t e;
                e = rq.pop_front();
                chk("rd_data", bus.h_rd_data, e.d);
                chk("rd_last", 32'(bus.h_rd_last), 32'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + 1);
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        host_width       = 2'b10;
        bus.h_wr_data    = '0;
        bus.h_wr_be      = '0;
        bus.h_wr_valid   = 1'b0;
        bus.h_wr_last    = 1'b0;
        bus.app_wr_next  = 1'b0;
        bus.app_rd_data  = '0;
        bus.app_rd_valid = 1'b0;
        bus.app_last_rd  = 1'b0;
        bus.h_rd_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_vals("rst");

        // 8-bit full word, held until app_wr_next
        push_w(32'h4433_2211, 4'h0);
        wr_beat(32'h11, 4'h1, 1'b0);
        wr_beat(32'h22, 4'h1, 1'b0);
        wr_beat(32'h33, 4'h1, 1'b0);
        wr_beat(32'h44, 4'h1, 1'b1);
        chk("hold_valid", 32'(bus.app_wr_valid), 32'd1);
        chk("hold_ready", 32'(bus.h_wr_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_valid_later", 32'(bus.app_wr_valid), 32'd1);
        chk("hold_ready_later", 32'(bus.h_wr_ready), 32'd0);
        bus.app_wr_next = 1'b1;
        @(posedge clk); #1;
        bus.app_wr_next = 1'b0;
        chk("next_valid_drop", 32'(bus.app_wr_valid), 32'd0);
        chk("next_ready_rise", 32'(bus.h_wr_ready), 32'd1);

        // 16-bit single beat with last, then two beats closing at MAXL
        host_width = 2'b01;
        push_w(32'h0000_BEEF, 4'hC);
        wr_beat(32'h0000_BEEF, 4'h3, 1'b1);
        consume_word();
        push_w(32'h5678_1234, 4'h8);
        wr_beat(32'h1234, 4'h3, 1'b0);
        wr_beat(32'h5678, 4'h1, 1'b0);
        consume_word();

        // 8-bit partial word, then a full word starting again at lane 0
        host_width = 2'b10;
        push_w(32'h00CC_BBAA, 4'h8);
        wr_beat(32'hAA, 4'h1, 1'b0);
        wr_beat(32'hBB, 4'h1, 1'b0);
        wr_beat(32'hCC, 4'h1, 1'b1);
        consume_word();
        push_w(32'h0403_0201, 4'h0);
        wr_beat(32'h01, 4'h1, 1'b0);
        wr_beat(32'h02, 4'h1, 1'b0);
        wr_beat(32'h03, 4'h1, 1'b0);
        wr_beat(32'h04, 4'h1, 1'b0);
        consume_word();

        // 32-bit passthrough with sparse enables
        host_width = 2'b00;
        push_w(32'hDEAD_BEEF, 4'hA);
        wr_beat(32'hDEAD_BEEF, 4'b0101, 1'b0);
        consume_word();

        // 8-bit read unpack
        host_width     = 2'b10;
        bus.h_rd_ready = 1'b1;
        push_r(32'hAA, 1'b0);
        push_r(32'hBB, 1'b0);
        push_r(32'hCC, 1'b0);
        push_r(32'hDD, 1'b1);
        rd_push(32'hDDCC_BBAA, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("rd8_empty", 32'(bus.h_rd_valid), 32'd0);
        chk("rd8_drained", 32'(rq.size()), 32'd0);

        // 32-bit overflow: fill, drop the fifth, then drain
        host_width     = 2'b00;
        bus.h_rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_r(32'hC0DE_0000 + 32'(i), (i == 3));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 4) chk("ovf_before_drop", 32'(rd_overflow), 32'd0);
            bus.app_rd_data  = 32'hC0DE_0000 + 32'(i);
            bus.app_last_rd  = (i == 3);
            bus.app_rd_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus.app_rd_valid = 1'b0;
        bus.app_last_rd  = 1'b0;
        chk("ovf_set", 32'(rd_overflow), 32'd1);
        chk("ovf_head_valid", 32'(bus.h_rd_valid), 32'd1);
        chk("ovf_head_data", bus.h_rd_data, 32'hC0DE_0000);
        chk("ovf_head_last", 32'(bus.h_rd_last), 32'd0);
        bus.h_rd_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("ovf_drained_valid", 32'(bus.h_rd_valid), 32'd0);
        chk("ovf_drained_q", 32'(rq.size()), 32'd0);
        bus.h_rd_ready = 1'b0;

        // underrun
        chk("underrun_before", 32'(wr_underrun), 32'd0);
        @(posedge clk); #1;
        bus.app_wr_next = 1'b1;
        @(posedge clk); #1;
        bus.app_wr_next = 1'b0;
        chk("underrun_set", 32'(wr_underrun), 32'd1);
        chk("underrun_no_valid", 32'(bus.app_wr_valid), 32'd0);

        // reset mid-assembly, then a fresh partial word from lane 0
        host_width = 2'b10;
        wr_beat(32'h77, 4'h1, 1'b0);
        wr_beat(32'h88, 4'h1, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_vals("midrst");
        push_w(32'h0000_6655, 4'hC);
        wr_beat(32'h55, 4'h1, 1'b0);
        wr_beat(32'h66, 4'h1, 1'b1);
        consume_word();

        repeat (4) @(posedge clk);
        #1;
        chk("wr_queue_empty", 32'(wq.size()), 32'd0);
        chk("rd_queue_empty", 32'(rq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
